// File: rtl/controlador_aviso.sv
// rtl/controlador_aviso.sv - seat-belt warning controller: confirm, blink lamp, timed buzzer bursts.
// Optional macro AVISO_REPETE_EN: buzzer repeats after a silent pause while the warning persists.
module controlador_aviso #(
  parameter int CONFIRMA_CICLOS = 4,
  parameter int MEIO_PERIODO    = 5,
  parameter int BUZZER_CICLOS   = 20,
  parameter int PAUSA_CICLOS    = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alerta,
  output logic       lampada,
  output logic       buzzer,
  output logic [1:0] estado,
  output logic [7:0] contagem_alertas
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONFIRMA = 2'b01,
    ALERTA   = 2'b10,
    SILENCIO = 2'b11
  } estado_t;

  localparam int CW = $clog2(CONFIRMA_CICLOS + 1);
  localparam int PW = $clog2(MEIO_PERIODO + 1);
`ifdef AVISO_REPETE_EN
  localparam int TMAX = (BUZZER_CICLOS > PAUSA_CICLOS) ? BUZZER_CICLOS : PAUSA_CICLOS;
`else
  localparam int TMAX = BUZZER_CICLOS;
`endif
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CONF_ULTIMO  = CW'(CONFIRMA_CICLOS - 1);
  localparam logic [PW-1:0] PISCA_ULTIMO = PW'(MEIO_PERIODO - 1);
  localparam logic [TW-1:0] BUZ_ULTIMO   = TW'(BUZZER_CICLOS - 1);
`ifdef AVISO_REPETE_EN
  localparam logic [TW-1:0] PAUSA_ULTIMO = TW'(PAUSA_CICLOS - 1);
`endif

  // Every timing parameter must describe at least one cycle.
  if (CONFIRMA_CICLOS < 1 || MEIO_PERIODO < 1 || BUZZER_CICLOS < 1 || PAUSA_CICLOS < 1) begin : g_param_invalido
    $error("controlador_aviso: timing parameters must be >= 1");
  end

  estado_t       st;
  logic [CW-1:0] conf_cnt;
  logic [PW-1:0] pisca_cnt;
  logic [TW-1:0] tempo;

  assign estado = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st               <= OCIOSO;
      conf_cnt         <= '0;
      pisca_cnt        <= '0;
      tempo            <= '0;
      lampada          <= 1'b0;
      buzzer           <= 1'b0;
      contagem_alertas <= 8'd0;
    end else begin
      unique case (st)
        OCIOSO, CONFIRMA: begin
          // conf_cnt is zero in OCIOSO, so one compare covers both states.
          if (!alerta) begin
            st       <= OCIOSO;
            conf_cnt <= '0;
          end else if (conf_cnt == CONF_ULTIMO) begin
            st        <= ALERTA;
            conf_cnt  <= '0;
            pisca_cnt <= '0;
            tempo     <= '0;
            lampada   <= 1'b1;
            buzzer    <= 1'b1;
            if (contagem_alertas != 8'hFF)
              contagem_alertas <= contagem_alertas + 8'd1;
          end else begin
            st       <= CONFIRMA;
            conf_cnt <= conf_cnt + 1'b1;
          end
        end

        ALERTA, SILENCIO: begin
          if (!alerta) begin
            st        <= OCIOSO;
            pisca_cnt <= '0;
            tempo     <= '0;
            lampada   <= 1'b0;
            buzzer    <= 1'b0;
          end else begin
            // Blink phase runs untouched across ALERTA<->SILENCIO.
            if (pisca_cnt == PISCA_ULTIMO) begin
              pisca_cnt <= '0;
              lampada   <= ~lampada;
            end else begin
              pisca_cnt <= pisca_cnt + 1'b1;
            end

            if (st == ALERTA) begin
              if (tempo == BUZ_ULTIMO) begin
                st     <= SILENCIO;
                buzzer <= 1'b0;
                tempo  <= '0;
              end else begin
                tempo <= tempo + 1'b1;
              end
            end else begin
`ifdef AVISO_REPETE_EN
              if (tempo == PAUSA_ULTIMO) begin
                st     <= ALERTA;
                buzzer <= 1'b1;
                tempo  <= '0;
              end else begin
                tempo <= tempo + 1'b1;
              end
`else
              tempo <= '0;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_aviso.sv
// tb/tb_controlador_aviso.sv - vector table, directed corner sequences and random run-length stimulus vs a timeline model.
module tb_controlador_aviso;

  localparam int C  = 4;
  localparam int MP = 5;
  localparam int B  = 20;
  localparam int P  = 40;

  logic       clk;
  logic       rst;
  logic       alerta;
  logic       lampada;
  logic       buzzer;
  logic [1:0] estado;
  logic [7:0] contagem_alertas;

  controlador_aviso #(
    .CONFIRMA_CICLOS(C),
    .MEIO_PERIODO(MP),
    .BUZZER_CICLOS(B),
    .PAUSA_CICLOS(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alerta(alerta),
    .lampada(lampada),
    .buzzer(buzzer),
    .estado(estado),
    .contagem_alertas(contagem_alertas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ciclo = 0;

  // Model: length of the current high run, and age of the warning since it began.
  int m_run  = 0;
  bit m_warn = 0;
  int m_age  = 0;
  int m_cnt  = 0;

  function automatic int m_buzzer();
    if (!m_warn) return 0;
`ifdef AVISO_REPETE_EN
    return ((m_age % (B + P)) < B) ? 1 : 0;
`else
    return (m_age < B) ? 1 : 0;
`endif
  endfunction

  function automatic int m_lampada();
    if (!m_warn) return 0;
    return (((m_age / MP) % 2) == 0) ? 1 : 0;
  endfunction

  function automatic int m_estado();
    if (m_warn) return (m_buzzer() == 1) ? 2 : 3;
    return (m_run == 0) ? 0 : 1;
  endfunction

  task automatic model_step(input logic r, input logic a);
    if (r) begin
      m_run = 0; m_warn = 0; m_age = 0; m_cnt = 0;
    end else if (!a) begin
      m_run = 0; m_warn = 0; m_age = 0;
    end else begin
      if (m_run < C) m_run++;
      if (m_warn) m_age++;
      else if (m_run == C) begin
        m_warn = 1;
        m_age  = 0;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic tick(input logic r, input logic a);
    rst    = r;
    alerta = a;
    @(posedge clk);
    #1;
    ciclo++;
    model_step(r, a);
  endtask

  task automatic chk(input string nome, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nome, ciclo, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("model_estado",   int'(estado),           m_estado());
    chk("model_lampada",  int'(lampada),          m_lampada());
    chk("model_buzzer",   int'(buzzer),           m_buzzer());
    chk("model_contagem", int'(contagem_alertas), m_cnt);
  endtask

  typedef struct {
    logic       rst;
    logic       alerta;
    logic [1:0] estado;
    logic       lampada;
    logic       buzzer;
    logic [7:0] contagem;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'd1};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};

    rst    = 1'b1;
    alerta = 1'b1;

    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].rst, vecs[i].alerta);
      chk($sformatf("vec%0d_estado", i),   int'(estado),           int'(vecs[i].estado));
      chk($sformatf("vec%0d_lampada", i),  int'(lampada),          int'(vecs[i].lampada));
      chk($sformatf("vec%0d_buzzer", i),   int'(buzzer),           int'(vecs[i].buzzer));
      chk($sformatf("vec%0d_contagem", i), int'(contagem_alertas), int'(vecs[i].contagem));
    end

    // Drop on the 8th cycle of ALERTA.
    for (int i = 0; i < C; i++) begin tick(0, 1); chk_model(); end
    for (int i = 1; i < 8; i++) begin tick(0, 1); chk_model(); end
    chk("drop_pre_estado", int'(estado), 2);
    tick(0, 0);
    chk("drop_estado",   int'(estado),           0);
    chk("drop_lampada",  int'(lampada),          0);
    chk("drop_buzzer",   int'(buzzer),           0);
    chk("drop_contagem", int'(contagem_alertas), 1);

    // Long hold: blink and buzzer timeline.
    for (int i = 0; i < C; i++) begin tick(0, 1); chk_model(); end
    chk("burst_entry_buzzer",   int'(buzzer),           1);
    chk("burst_entry_contagem", int'(contagem_alertas), 2);
    for (int k = 1; k < 150; k++) begin
      tick(0, 1);
      chk_model();
      if (k == 4)  chk("burst_lamp_k4",   int'(lampada), 1);
      if (k == 5)  chk("burst_lamp_k5",   int'(lampada), 0);
      if (k == 10) chk("burst_lamp_k10",  int'(lampada), 1);
      if (k == 19) chk("burst_buzzer_k19", int'(buzzer), 1);
      if (k == 20) begin
        chk("burst_estado_k20", int'(estado), 3);
        chk("burst_buzzer_k20", int'(buzzer), 0);
      end
`ifdef AVISO_REPETE_EN
      if (k == 59) chk("repeat_buzzer_k59", int'(buzzer), 0);
      if (k == 60) begin
        chk("repeat_estado_k60", int'(estado), 2);
        chk("repeat_buzzer_k60", int'(buzzer), 1);
      end
`else
      if (k == 60 || k == 149) chk("hold_buzzer_silent", int'(buzzer), 0);
`endif
    end
    chk("burst_contagem_end", int'(contagem_alertas), 2);
    tick(0, 0);
    chk_model();

    // Saturation: 256 confirm/drop events.
    tick(1, 0);
    for (int e = 0; e < 256; e++) begin
      for (int i = 0; i < C; i++) tick(0, 1);
      chk("sat_estado_alerta", int'(estado), 2);
      tick(0, 0);
    end
    chk_model();
    chk("sat_contagem", int'(contagem_alertas), 255);

    // Reset in the middle of ALERTA.
    for (int i = 0; i < C + 3; i++) begin tick(0, 1); chk_model(); end
    tick(1, 1);
    chk("rst_mid_estado",   int'(estado),           0);
    chk("rst_mid_lampada",  int'(lampada),          0);
    chk("rst_mid_buzzer",   int'(buzzer),           0);
    chk("rst_mid_contagem", int'(contagem_alertas), 0);

    // Random run lengths against the model.
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 29) == 0) begin
        tick(1, $urandom_range(0, 1) == 1);
        chk_model();
      end
      for (int i = 0, n = $urandom_range(1, 90); i < n; i++) begin
        tick(0, 1);
        chk_model();
      end
      for (int i = 0, n = $urandom_range(1, 4); i < n; i++) begin
        tick(0, 0);
        chk_model();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/controlador_aviso.md
CONTROLADOR_AVISO -- requirements
Module: controlador_aviso

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and rst are listed first.
REQ-002 Parameter CONFIRMA_CICLOS, default 4: the number of consecutive high samples of alerta required before warning.
REQ-003 Parameter MEIO_PERIODO, default 5: lampada half-period, in cycles.
REQ-004 Parameter BUZZER_CICLOS, default 20: the number of cycles the buzzer sounds per burst.
REQ-005 Parameter PAUSA_CICLOS, default 40: silent gap before the buzzer repeats (only used when AVISO_REPETE_EN is defined).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 alerta  input  1  warning request from the seat-belt alarm stage (its luz_de_advertencia output).
REQ-009 lampada  output  1  blinking dashboard lamp.
REQ-010 buzzer  output  1  audible warning.
REQ-011 estado  output  2  current FSM state.
REQ-012 contagem_alertas  output  8  number of confirmed warning events, saturating.

Function
REQ-013 All outputs SHALL be registered, and alerta SHALL be sampled only on rising clk edges.
REQ-014 FSM encoding SHALL be: OCIOSO=00, CONFIRMA=01, ALERTA=10, SILENCIO=11.
REQ-015 In OCIOSO, lampada=0 and buzzer=0; the first edge that samples alerta=1 SHALL move the FSM to CONFIRMA with the confirm count set to 1.
REQ-016 In CONFIRMA, alerta=0 at any edge SHALL return the FSM to OCIOSO and clear the confirm count.
REQ-017 In CONFIRMA, the FSM SHALL enter ALERTA at the edge that completes CONFIRMA_CICLOS consecutive high samples; with the default, estado=01 after E0, E1 and E2, and 10 after E3.
REQ-018 On entry to ALERTA from CONFIRMA, the block SHALL, at the same edge:
- set lampada=1 and buzzer=1;
- clear the blink and buzzer counters;
- increment contagem_alertas, saturating at 255.
REQ-019 In ALERTA and SILENCIO, lampada SHALL toggle every MEIO_PERIODO cycles; the blink phase SHALL be continuous across ALERTA<->SILENCIO transitions.
REQ-020 In ALERTA, after BUZZER_CICLOS cycles with buzzer=1, the FSM SHALL move to SILENCIO with buzzer=0.
REQ-021 In ALERTA or SILENCIO, alerta=0 SHALL move the FSM to OCIOSO at that edge, forcing lampada=0 and buzzer=0.
REQ-022 alerta=0 SHALL take priority over any simultaneous timeout.
REQ-023 A glitch on alerta shorter than CONFIRMA_CICLOS cycles SHALL NOT assert lampada or buzzer, and SHALL NOT change contagem_alertas.
REQ-024 All counters SHALL be wide enough for their parameter values, and SHALL NOT wrap within a state.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set estado=OCIOSO, lampada=0, buzzer=0, contagem_alertas=0, and clear all internal counters; rst SHALL dominate alerta.
REQ-026 Reset asserted mid-ALERTA SHALL silence the outputs at that same edge.
REQ-027 After rst deasserts, a new full confirmation SHALL be required before any warning.

Configuration
REQ-028 Macro AVISO_REPETE_EN SHALL control buzzer repetition.
REQ-029 With AVISO_REPETE_EN defined, SILENCIO SHALL return to ALERTA after PAUSA_CICLOS cycles; on that return, buzzer=1 and the buzzer counter is cleared, and contagem_alertas is NOT incremented.
REQ-030 Without AVISO_REPETE_EN, SILENCIO SHALL hold until alerta=0 or rst, and PAUSA_CICLOS logic SHALL be absent.

Verification
REQ-031 Reset check: rst=1 for 2 cycles with alerta=1 -> estado=00, lampada=0, buzzer=0, contagem_alertas=0.
REQ-032 Glitch check: alerta high for 3 cycles, then low -> estado goes 01 then back to 00, buzzer never 1, count stays 0.
REQ-033 Confirmation and burst check: alerta held high, defaults ->
- estado=10 after the 4th sample;
- lampada toggles every 5 cycles;
- buzzer stays high for 20 cycles, then estado=11 and buzzer=0;
- count=1.
REQ-034 Drop check: alerta drops at cycle 8 of ALERTA -> estado=00, lampada=0, buzzer=0 at that edge; count stays 1.
REQ-035 Repeat check (AVISO_REPETE_EN defined): alerta held -> buzzer pattern 20 on / 40 off repeating, count stays 1; without the macro, buzzer stays 0 indefinitely after the first burst.
REQ-036 Saturation and reset check: 256 confirm/drop events -> count=255; rst asserted mid-ALERTA -> all outputs 0 at that edge.
